// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, key map and scanner state encoding shared with the calculator control FSM
package keypad_pkg;
  localparam logic NUMBER = 1'b1;
  localparam logic SYMBOL = 1'b0;
  localparam logic [3:0] A_BUT = 4'hA, B_BUT = 4'hB, C_BUT = 4'hC, D_BUT = 4'hD, E_BUT = 4'hE, FN_BUT = 4'hF;
  typedef logic [1:0] state_t;
  localparam state_t SCAN = 2'd0, DEBOUNCE = 2'd1, PRESSED = 2'd2, RELEASE = 2'd3;
  // Indexed by {row, col}; columns run left to right on the keypad.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, A_BUT,
    4'h4, 4'h5, 4'h6, B_BUT,
    4'h7, 4'h8, 4'h9, C_BUT,
    E_BUT, 4'h0, FN_BUT, D_BUT
  };
  function automatic logic [3:0] key_lookup(input logic [1:0] col, input logic [1:0] row);
    return KEY_MAP[{row, col}];
  endfunction
  function automatic logic key_class(input logic [3:0] k);
    return (k < 4'd10) ? NUMBER : SYMBOL;
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad encoder return, column drive and key event outputs
interface keypad_scanner_if;
  logic [1:0] row_result;
  logic       valid_out;
  logic [1:0] col_selector;
  logic [3:0] key;
  logic       keytype;
  logic       key_valid;
  logic       key_strobe;
  modport master (input row_result, valid_out, output col_selector, key, keytype, key_valid, key_strobe);
  modport slave (output row_result, valid_out, input col_selector, key, keytype, key_valid, key_strobe);
endinterface

// File: rtl/keypad_scanner_sync2.sv
// sync2: two-flop synchroniser for asynchronous keypad encoder signals
module sync2 #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  assign q = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column scan, settle/debounce and single key event per press for a 4x4 keypad
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input logic clock,
  input logic reset,
  keypad_scanner_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    rs;
  logic          vs;
  state_t        state_q, state_d;
  logic [1:0]    col_q, col_d, cand_q, cand_d;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [BW-1:0] deb_q, deb_d;
  logic [3:0]    key_q, key_d, k_lu;
  logic          keytype_q, keytype_d, key_valid_q, key_valid_d, key_strobe_q, key_strobe_d;
  logic          settled, deb_done;
  sync2 #(.W(2)) u_row (.clock(clock), .reset(reset), .d(kp.row_result), .q(rs));
  sync2 #(.W(1)) u_vld (.clock(clock), .reset(reset), .d(kp.valid_out), .q(vs));
  assign k_lu     = key_lookup(col_q, cand_q);
  assign settled  = settle_q >= SW'(SETTLE_CYCLES);
  assign deb_done = deb_q == BW'(DEBOUNCE_CYCLES - 1);
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    cand_d       = cand_q;
    div_d        = div_q;
    settle_d     = settle_q;
    deb_d        = deb_q;
    key_d        = key_q;
    keytype_d    = keytype_q;
    key_valid_d  = key_valid_q;
    key_strobe_d = 1'b0;
    case (state_q)
      SCAN:
        if (div_q == DW'(SCAN_DIV - 1)) begin
          col_d    = col_q + 2'd1;
          div_d    = '0;
          settle_d = '0;
        end else begin
          div_d    = div_q + 1'b1;
          settle_d = settled ? settle_q : settle_q + 1'b1;
          if (settled && vs) begin
            cand_d  = rs;
            deb_d   = '0;
            state_d = DEBOUNCE;
          end
        end
      DEBOUNCE:
        if (vs && rs == cand_q) begin
          deb_d = deb_done ? BW'(DEBOUNCE_CYCLES) : deb_q + 1'b1;
          if (deb_done) begin
            key_d        = k_lu;
            keytype_d    = key_class(k_lu);
            key_strobe_d = 1'b1;
            key_valid_d  = 1'b1;
            state_d      = PRESSED;
          end
        end else begin
          settle_d = '0;
          state_d  = SCAN;
        end
      PRESSED:
        if (!vs) begin
          deb_d   = '0;
          state_d = RELEASE;
        end
      default:
        if (vs) begin
          deb_d   = '0;
          state_d = PRESSED;
        end else if (deb_done) begin
          deb_d       = BW'(DEBOUNCE_CYCLES);
          key_valid_d = 1'b0;
          col_d       = col_q + 2'd1;
          div_d       = '0;
          settle_d    = '0;
          state_d     = SCAN;
        end else begin
          deb_d = deb_q + 1'b1;
        end
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q      <= SCAN;
      col_q        <= '0;
      cand_q       <= '0;
      div_q        <= '0;
      settle_q     <= '0;
      deb_q        <= '0;
      key_q        <= '0;
      keytype_q    <= 1'b0;
      key_valid_q  <= 1'b0;
      key_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      cand_q       <= cand_d;
      div_q        <= div_d;
      settle_q     <= settle_d;
      deb_q        <= deb_d;
      key_q        <= key_d;
      keytype_q    <= keytype_d;
      key_valid_q  <= key_valid_d;
      key_strobe_q <= key_strobe_d;
    end
  assign kp.col_selector = col_q;
  assign kp.key          = key_q;
  assign kp.keytype      = keytype_q;
  assign kp.key_valid    = key_valid_q;
  assign kp.key_strobe   = key_strobe_q;
endmodule
